pipe_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage 16-bit pipeline.

---
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: RUN/DRAIN/HALTED FSM plus saturating stall counter.
// Latency: stage enables are combinational from state+inputs; halted/drain_err/stall_cnt registered. Backpressure: dmem_stall freezes every stage.
module pipe_ctrl #(
    parameter int DRAIN_MAX = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_vld,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_vld,
    input  logic             id_halt,
    input  logic             ex_memread,
    input  logic [2:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             wb_halt,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             drain_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CTR_W = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    logic [CTR_W-1:0] drain_ctr;
    logic             load_use;
    logic             fetch_stall;
    logic             stall_evt;

    assign load_use = ex_memread &
                      ((id_rs_vld & (id_rs == ex_rd)) | (id_rt_vld & (id_rt == ex_rd)));

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_bubble = 1'b0;
        fetch_stall  = 1'b0;
        if (rst || state == HALTED) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_we      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            if (dmem_stall) begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_bubble = 1'b1;
            end else if (ex_br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else if (imem_stall) begin
                pc_we       = 1'b0;
                ifid_flush  = 1'b1;
                fetch_stall = 1'b1;
            end
            // No new instructions enter while the HALT drains out.
            if (state == DRAIN) begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // A fetch miss is a stall cycle too, even though IF_ID loads a NOP rather than holding.
    assign stall_evt = ~ifid_we | fetch_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_ctr <= '0;
            halted    <= 1'b0;
            drain_err <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (state != HALTED && stall_evt && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
            case (state)
                RUN: begin
                    if (id_halt && !dmem_stall && !ex_br_taken && !load_use) begin
                        state     <= DRAIN;
                        drain_ctr <= '0;
                    end
                end
                DRAIN: begin
                    if (!dmem_stall) begin
                        if (wb_halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else if (drain_ctr == CTR_W'(DRAIN_MAX - 1)) begin
                            state     <= HALTED;
                            halted    <= 1'b1;
                            drain_err <= 1'b1;
                        end else begin
                            drain_ctr <= drain_ctr + CTR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule
